// File: rtl/uadd_seq_if.sv
// ---------------------------------------------------------------------------
// uadd_seq_if -- operand/result bundle for the slice-serial adder uadd_seq.
//
// Handshake rules (both channels, strict valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer keeps valid and its data steady until that transfer; the
//   consumer may raise or drop ready at any time.
//
// Signals
//   in_valid  : operand pair offered          (master -> slave)
//   in_ready  : adder can accept operands     (slave  -> master)
//   a, b      : TOTAL_W-bit unsigned operands (master -> slave)
//   cin       : carry-in, present only with UADD_SEQ_CIN_EN defined
//   out_valid : result available              (slave  -> master)
//   out_ready : consumer takes the result     (master -> slave)
//   sum       : (a + b + cin) mod 2^TOTAL_W   (slave  -> master)
//   carry_out : carry out of the top slice    (slave  -> master)
//
// Configuration macro: UADD_SEQ_CIN_EN adds the cin signal.
// ---------------------------------------------------------------------------
interface uadd_seq_if #(
    parameter int TOTAL_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [TOTAL_W-1:0] a;
    logic [TOTAL_W-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [TOTAL_W-1:0] sum;
    logic               carry_out;
`ifdef UADD_SEQ_CIN_EN
    logic               cin;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
`endif
endinterface

// File: rtl/uadd_seq.sv
// ---------------------------------------------------------------------------
// uadd_seq -- unsigned adder that reuses one CHUNK_W-bit adder slice over
// CHUNKS cycles to add two TOTAL_W-bit operands (TOTAL_W = CHUNK_W*CHUNKS).
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset; release is synchronised inside
//   bus      : uadd_seq_if.slave -- operand channel (in_valid/in_ready/a/b
//              [/cin]) and result channel (out_valid/out_ready/sum/carry_out)
//   state_o  : FSM state for observation (IDLE=0, RUN=1, DONE=2)
//
// Operation
//   IDLE : in_ready=1; an accepted pair is captured and the FSM goes to RUN.
//   RUN  : one slice per cycle, least significant first, carry rippling
//          through carry_q. The last slice moves the FSM to DONE, so
//          out_valid rises CHUNKS cycles after the accepting edge.
//   DONE : out_valid=1; sum/carry_out held until out_ready, then IDLE.
//
// Configuration macro: UADD_SEQ_CIN_EN -- adds bus.cin, loaded into the
// carry register at the accepting edge. Without it the initial carry is 0.
// ---------------------------------------------------------------------------
module uadd_seq #(
    parameter int CHUNK_W = 4,
    parameter int CHUNKS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    uadd_seq_if.slave  bus,
    output logic [1:0] state_o
);
    localparam int TOTAL_W = CHUNK_W * CHUNKS;
    // Keep the index at least one bit wide so CHUNKS=1 still elaborates.
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [TOTAL_W-1:0] a_q;
    logic [TOTAL_W-1:0] b_q;
    logic [TOTAL_W-1:0] sum_q;
    logic               carry_out_q;

    logic [1:0]         rst_sync_q;
    logic               rst_int_n;

    logic [CHUNK_W:0]   add_d;
    logic               init_carry_d;

    // Reset asserts immediately and releases two clock edges after rst_n
    // rises, so the FSM cannot accept before the second edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

`ifdef UADD_SEQ_CIN_EN
    assign init_carry_d = bus.cin;
`else
    assign init_carry_d = 1'b0;
`endif

    // The one shared slice adder: slice idx_q of the captured operands plus
    // the running carry. Bit CHUNK_W is the carry into the next slice.
    always_comb begin
        add_d = {1'b0, a_q[int'(idx_q)*CHUNK_W +: CHUNK_W]}
              + {1'b0, b_q[int'(idx_q)*CHUNK_W +: CHUNK_W]}
              + {{CHUNK_W{1'b0}}, carry_q};
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        carry_q <= init_carry_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= add_d[CHUNK_W-1:0];
                    carry_q <= add_d[CHUNK_W];
                    if (idx_q == LAST_IDX) begin
                        carry_out_q <= add_d[CHUNK_W];
                        idx_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers are untouched here, so they stay
                    // stable for as long as the consumer stalls.
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_uadd_seq.sv
// ---------------------------------------------------------------------------
// tb_uadd_seq -- self-checking bench for uadd_seq.
//   dut0 : CHUNK_W=4, CHUNKS=4 (16-bit)   dut1 : CHUNK_W=3, CHUNKS=1 (3-bit)
// Expected values come from a hand-written vector table and from plain
// integer addition (a + b + cin) on the operands.
// Define UADD_SEQ_CIN_EN for both bench and RTL to exercise the carry-in.
// ---------------------------------------------------------------------------
module tb_uadd_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uadd_seq_if #(.TOTAL_W(16)) bus0 ();
    uadd_seq_if #(.TOTAL_W(3))  bus1 ();

    logic [1:0] st0;
    logic [1:0] st1;

    uadd_seq #(.CHUNK_W(4), .CHUNKS(4)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus0),
        .state_o (st0)
    );

    uadd_seq #(.CHUNK_W(3), .CHUNKS(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1),
        .state_o (st1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: {carry_out, sum} expected for the transaction in flight.
    logic [16:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_co;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    task automatic scramble0();
        bus0.in_valid = 1'($urandom_range(0, 1));
        bus0.a        = 16'($urandom);
        bus0.b        = 16'($urandom);
`ifdef UADD_SEQ_CIN_EN
        bus0.cin      = 1'($urandom_range(0, 1));
`endif
    endtask

    // One transaction on dut0, starting and ending at a negedge in IDLE.
    task automatic txn0(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [16:0] exp, input int stall);
        int cnt;
        logic [16:0] e;
        chk("idle_in_ready", 32'(bus0.in_ready), 32'd1);
        bus0.a        = a;
        bus0.b        = b;
`ifdef UADD_SEQ_CIN_EN
        bus0.cin      = c;
`endif
        bus0.in_valid = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("run_in_ready", 32'(bus0.in_ready), 32'd0);
        cnt = 0;
        while (!bus0.out_valid && cnt < 20) begin
            scramble0();
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd4);
        e = exp_q.pop_front();
        chk("sum", 32'(bus0.sum), 32'(e[15:0]));
        chk("carry_out", 32'(bus0.carry_out), 32'(e[16]));
        bus0.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            scramble0();
            @(negedge clk);
            chk("hold_out_valid", 32'(bus0.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus0.in_ready), 32'd0);
            chk("hold_sum", 32'(bus0.sum), 32'(e[15:0]));
            chk("hold_carry_out", 32'(bus0.carry_out), 32'(e[16]));
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b0;
        chk("post_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus0.in_ready), 32'd1);
    endtask

    // One transaction on the single-slice dut1.
    task automatic txn1(input logic [2:0] a, input logic [2:0] b, input logic [3:0] exp);
        int cnt;
        bus1.a        = a;
        bus1.b        = b;
        bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        cnt = 0;
        while (!bus1.out_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("c1_latency", 32'(cnt), 32'd1);
        chk("c1_sum", 32'(bus1.sum), 32'(exp[2:0]));
        chk("c1_carry_out", 32'(bus1.carry_out), 32'(exp[3]));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk("c1_post_out_valid", 32'(bus1.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [2:0]  sa;
        logic [2:0]  sb;

        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
`ifdef UADD_SEQ_CIN_EN
        bus0.cin       = 1'b0;
        bus1.cin       = 1'b0;
`endif

        // ---- reset state ---------------------------------------------------
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_sum", 32'(bus0.sum), 32'd0);
        chk("rst_carry_out", 32'(bus0.carry_out), 32'd0);
        chk("rst_c1_out_valid", 32'(bus1.out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ---- directed vector table -----------------------------------------
        vecs.push_back('{16'h0002, 16'h0004, 1'b0, 16'h0006, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0});
        vecs.push_back('{16'h00FF, 16'h0000, 1'b0, 16'h00FF, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
`ifdef UADD_SEQ_CIN_EN
        vecs.push_back('{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1});
`endif
        foreach (vecs[i]) begin
            txn0(vecs[i].a, vecs[i].b, vecs[i].cin,
                 {vecs[i].exp_co, vecs[i].exp_sum}, (i == 2) ? 3 : 0);
        end

        // ---- single-slice configuration ------------------------------------
        txn1(3'b010, 3'b100, 4'b0110);
        txn1(3'b111, 3'b001, 4'b1000);
        for (int i = 0; i < 20; i++) begin
            sa = 3'($urandom);
            sb = 3'($urandom);
            txn1(sa, sb, {1'b0, sa} + {1'b0, sb});
        end

        // ---- reset in the middle of RUN ------------------------------------
        bus0.a        = 16'hABCD;
        bus0.b        = 16'h1111;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("mid_rst_sum", 32'(bus0.sum), 32'd0);
        chk("mid_rst_carry_out", 32'(bus0.carry_out), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus0.a        = 16'h1234;
        bus0.b        = 16'h1111;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        chk("sync_no_early_accept", 32'(bus0.in_ready), 32'd1);
        chk("discarded_no_result", 32'(bus0.out_valid), 32'd0);
        cnt = 0;
        while (bus0.in_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        bus0.in_valid = 1'b0;
        cnt = 0;
        while (!bus0.out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("after_rst_out_valid", 32'(bus0.out_valid), 32'd1);
        chk("after_rst_sum", 32'(bus0.sum), 32'h2345);
        chk("after_rst_carry_out", 32'(bus0.carry_out), 32'd0);
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        chk("after_rst_idle", 32'(bus0.in_ready), 32'd1);

        // ---- randomized back-to-back traffic -------------------------------
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 10 == 0) rb = ~ra;
`ifdef UADD_SEQ_CIN_EN
            rc = 1'($urandom_range(0, 1));
`else
            rc = 1'b0;
`endif
            txn0(ra, rb, rc, ref_add(ra, rb, rc), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
